fma16_stream_unit: RTL and testbench
====================================

Name: fma16_stream_unit

Overview:
Clocked request/response wrapper around the combinational fma16 core. It is the hardware counterpart of the vector-driving bench: it accepts operand packets over a valid/ready request channel and registers them. It evaluates each packet through fma16 and queues {result, flags, tag} in a response FIFO drained over a valid/ready response channel. It is the attachment point for streaming FMA traffic from a sequencer or memory-mapped front end.

Parameters:
DEPTH, 4, response FIFO entries (power of two, >=2)
TAGW, 4, width of per-request sequence tag

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous reset, active-low (0 = reset asserted)
req_valid  in  1  request packet present
req_ready  out  1  unit can accept a packet this cycle
req_x  in  16  half-precision multiplicand
req_y  in  16  half-precision multiplier
req_z  in  16  half-precision addend
req_ctrl  in  8  control byte; bits [5:0] = {roundmode[1:0], mul, add, negp, negz}; bits [7:6] ignored
rsp_valid  out  1  head-of-FIFO response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  fma16 result
rsp_flags  out  4  {invalid, overflow, underflow, inexact}
rsp_tag  out  TAGW  tag of the originating request
occupancy  out  $clog2(DEPTH)+1  responses held in FIFO
busy  out  1  s1_valid | (occupancy != 0)

Behaviour:
- Reset (reset==0 at a clk edge): s1_valid=0, FIFO pointers=0, occupancy=0, tag counter=0. req_ready=1 and rsp_valid=0 the cycle after. Payload registers are don't-care. Reset mid-operation discards the staged packet and all queued responses. No response for them is ever produced.
- Request accept: req_valid & req_ready at an edge. On acceptance, latch x, y, z, ctrl[5:0] and the current tag into stage register S1, set s1_valid=1, and increment the tag counter modulo 2^TAGW (wraps 2^TAGW-1 -> 0).
- req_ready = (occupancy + s1_valid) < DEPTH. This is slot reservation: every staged packet has a guaranteed FIFO entry, so S1 never stalls. req_ready is independent of req_valid (no combinational loop).
- Stage 1 -> FIFO: while s1_valid=1, fma16 is driven from the S1 registers. At the next edge, {result, flags, s1_tag} is pushed unconditionally. s1_valid clears unless a new request is accepted at the same edge, in which case S1 reloads and stays valid.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N+1 (2-cycle minimum), provided the FIFO is otherwise empty. Throughput is 1 packet/cycle when rsp_ready is held 1.
- Response: rsp_valid = occupancy != 0. rsp_* present the head entry directly from FIFO storage. Pop occurs on rsp_valid & rsp_ready. rsp_* must stay stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous push and pop: occupancy unchanged, pointers both advance. Push into a full FIFO is impossible by construction; a verification assertion must flag it. Pop when empty is ignored.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits equal.
- Ordering: responses leave in strict acceptance order. Tags are consecutive modulo 2^TAGW.
- fma16 semantics (special cases, rounding, flags) are inherited unchanged. This block adds no arithmetic.

Test Plan:
- Single op: after reset, send x=3C00 y=4000 z=3C00 ctrl=8'h1C (RNE, mul, add) with rsp_ready=1. Expect rsp_valid exactly 2 cycles after accept, result=4200, flags=0000, tag=0.
- Overflow passthrough: x=7BFF y=7BFF z=0000 ctrl=8'h1C. Expect result=7C00, flags=0101 (overflow, inexact), matching the combinational fma16 for the same inputs.
- Backpressure/full: rsp_ready=0, stream 6 requests with DEPTH=4. Expect req_ready=0 once occupancy+s1_valid=4, exactly 4 entries queued, and head result stable. Then rsp_ready=1: expect tags 0..3 in order, with remaining requests accepted as slots free.
- Full-rate streaming: 32 back-to-back requests with rsp_ready=1. Expect 1 response/cycle and tags 0..15,0..15 (wrap at TAGW=4). Each result must equal the fma16 model for the same inputs.
- Simultaneous push/pop at occupancy=DEPTH-1 with rsp_ready toggled randomly. Expect occupancy never exceeds DEPTH, no lost or duplicated tags, and the push-when-full assertion never fires.
- Reset mid-stream: drop reset to 0 for 1 cycle while 3 responses are queued and S1 is valid. Expect rsp_valid=0, occupancy=0, busy=0 and req_ready=1 the next cycle. The first post-reset response must carry tag=0.

Source files
------------

// File: rtl/fma16_stream_unit.sv
// Streaming request/response wrapper around a combinational half-precision FMA.
// One staging register feeds fma16; results queue in a response FIFO with per-request tags.

module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic [1:0]  roundmode,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  // Exact sum held as a fixed-point integer scaled by 2^48 (LSB = 2^-48).
  localparam int SW = 82;

  logic [15:0]   ye, ze;
  logic          ps, zs, rs;
  logic          xnan, ynan, znan, snan;
  logic          xinf, yinf, zinf, xzero, yzero;
  logic          pinf, invalid, ovf_inf;
  logic [21:0]   prod;
  logic [6:0]    pshift, zshift, lpos, lsbpos, ebase;
  logic [SW-1:0] pmag, zmag, smag;
  logic [10:0]   mant;
  logic          guard, sticky, rup, inexact;
  logic [16:0]   bits;

  function automatic logic [10:0] sig_of(input logic [15:0] v);
    return {(v[14:10] != 5'd0), v[9:0]};
  endfunction

  function automatic logic [6:0] exp_of(input logic [15:0] v);
    return (v[14:10] == 5'd0) ? 7'd1 : {2'b00, v[14:10]};
  endfunction

  function automatic logic is_nan(input logic [15:0] v);
    return (&v[14:10]) && (v[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] v);
    return (&v[14:10]) && (v[9:0] == 10'd0);
  endfunction

  assign ye    = mul ? y : 16'h3C00;
  assign ze    = add ? z : 16'h0000;
  assign ps    = x[15] ^ ye[15] ^ negp;
  assign zs    = add ? (z[15] ^ negz) : ps;
  assign xnan  = is_nan(x);
  assign ynan  = is_nan(ye);
  assign znan  = is_nan(ze);
  assign snan  = (xnan & ~x[9]) | (ynan & ~ye[9]) | (znan & ~ze[9]);
  assign xinf  = is_inf(x);
  assign yinf  = is_inf(ye);
  assign zinf  = is_inf(ze);
  assign xzero = (x[14:0] == 15'd0);
  assign yzero = (ye[14:0] == 15'd0);
  assign pinf  = xinf | yinf;
  assign invalid = (xinf & yzero) | (xzero & yinf) | (pinf & zinf & (ps != zs));

  assign prod   = sig_of(x) * sig_of(ye);
  assign pshift = exp_of(x) + exp_of(ye) - 7'd2;
  assign zshift = exp_of(ze) + 7'd23;
  assign pmag   = SW'(prod) << pshift;
  assign zmag   = SW'(sig_of(ze)) << zshift;

  always_comb begin
    smag = '0;
    rs   = ps;
    if (ps == zs) begin
      smag = pmag + zmag;
      rs   = ps;
    end else if (pmag >= zmag) begin
      smag = pmag - zmag;
      rs   = ps;
    end else begin
      smag = zmag - pmag;
      rs   = zs;
    end

    lpos = '0;
    for (int i = 0; i < SW; i++) begin
      if (smag[i]) lpos = 7'(i);
    end

    // Below 2^-14 the LSB pins at 2^-24 (bit 24), giving subnormal results.
    lsbpos  = (lpos >= 7'd34) ? lpos - 7'd10 : 7'd24;
    ebase   = (lpos >= 7'd34) ? lpos - 7'd34 : 7'd0;
    mant    = 11'(smag >> lsbpos);
    guard   = smag[lsbpos - 7'd1];
    sticky  = |(smag & ((SW'(1) << (lsbpos - 7'd1)) - SW'(1)));
    inexact = guard | sticky;

    case (roundmode)
      2'b00:   rup = 1'b0;
      2'b01:   rup = guard & (sticky | mant[0]);
      2'b10:   rup = rs & inexact;
      default: rup = ~rs & inexact;
    endcase

    // Mantissa carry propagates into the exponent field naturally.
    bits    = {ebase, 10'd0} + {6'd0, mant} + {16'd0, rup};
    ovf_inf = (roundmode == 2'b01) | ((roundmode == 2'b10) & rs) | ((roundmode == 2'b11) & ~rs);

    result = {rs, bits[14:0]};
    flags  = {2'b00, inexact & (lpos < 7'd34), inexact};
    if (smag == '0) begin
      result = {((ps == zs) ? ps : (roundmode == 2'b10)), 15'd0};
      flags  = 4'b0000;
    end else if (bits >= 17'h07C00) begin
      result = {rs, (ovf_inf ? 15'h7C00 : 15'h7BFF)};
      flags  = 4'b0101;
    end

    if (xnan | ynan | znan) begin
      result = 16'h7E00;
      flags  = {snan, 3'b000};
    end else if (invalid) begin
      result = 16'h7E00;
      flags  = 4'b1000;
    end else if (pinf) begin
      result = {ps, 15'h7C00};
      flags  = 4'b0000;
    end else if (zinf) begin
      result = {zs, 15'h7C00};
      flags  = 4'b0000;
    end
  end
endmodule

module fma16_stream_unit #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [15:0]              req_x,
  input  logic [15:0]              req_y,
  input  logic [15:0]              req_z,
  input  logic [7:0]               req_ctrl,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_result,
  output logic [3:0]               rsp_flags,
  output logic [TAGW-1:0]          rsp_tag,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     busy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0]   DEPTH_V = DEPTH[PW+1:0];
  localparam logic [PW:0]     PTR_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [TAGW-1:0] TAG_ONE = {{(TAGW-1){1'b0}}, 1'b1};

  logic            s1_valid;
  logic [15:0]     s1_x, s1_y, s1_z;
  logic [5:0]      s1_ctrl;
  logic [TAGW-1:0] s1_tag, tag_cnt;
  logic [PW:0]     wptr, rptr;
  logic            accept, push, pop, full;
  logic [15:0]     fma_result;
  logic [3:0]      fma_flags;
  logic            unused_ctrl_bits;

  logic [15:0]     mem_result [DEPTH];
  logic [3:0]      mem_flags  [DEPTH];
  logic [TAGW-1:0] mem_tag    [DEPTH];

  assign unused_ctrl_bits = ^req_ctrl[7:6];

  // Counting the staged packet reserves its FIFO slot, so S1 never has to stall.
  assign occupancy = wptr - rptr;
  assign req_ready = ({1'b0, occupancy} + {{(PW+1){1'b0}}, s1_valid}) < DEPTH_V;
  assign accept    = req_valid & req_ready;
  assign push      = s1_valid;
  assign rsp_valid = (occupancy != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = s1_valid | rsp_valid;
  assign full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

  assign rsp_result = mem_result[rptr[PW-1:0]];
  assign rsp_flags  = mem_flags[rptr[PW-1:0]];
  assign rsp_tag    = mem_tag[rptr[PW-1:0]];

  fma16 u_fma16 (
    .x         (s1_x),
    .y         (s1_y),
    .z         (s1_z),
    .roundmode (s1_ctrl[5:4]),
    .mul       (s1_ctrl[3]),
    .add       (s1_ctrl[2]),
    .negp      (s1_ctrl[1]),
    .negz      (s1_ctrl[0]),
    .result    (fma_result),
    .flags     (fma_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      tag_cnt  <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) tag_cnt <= tag_cnt + TAG_ONE;
      if (push)   wptr    <= wptr + PTR_ONE;
      if (pop)    rptr    <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_x    <= req_x;
      s1_y    <= req_y;
      s1_z    <= req_z;
      s1_ctrl <= req_ctrl[5:0];
      s1_tag  <= tag_cnt;
    end
    if (push) begin
      mem_result[wptr[PW-1:0]] <= fma_result;
      mem_flags[wptr[PW-1:0]]  <= fma_flags;
      mem_tag[wptr[PW-1:0]]    <= s1_tag;
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));
endmodule

// File: tb/tb_fma16_stream_unit.sv
// Directed bench for fma16_stream_unit: hand-computed FMA vectors, latency,
// backpressure, full-rate streaming, random response stalls and mid-stream reset.
module tb_fma16_stream_unit;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam int NV    = 17;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [15:0]     req_x = '0, req_y = '0, req_z = '0;
  logic [7:0]      req_ctrl = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [15:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic [TAGW-1:0] rsp_tag;
  logic [2:0]      occupancy;
  logic            busy;

  always #5 clk = ~clk;

  fma16_stream_unit #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .occupancy(occupancy), .busy(busy)
  );

  // Vectors: x, y, z, ctrl -> hand-computed result and {invalid, overflow, underflow, inexact}.
  logic [15:0] vx [NV] = '{16'h3C00, 16'h7BFF, 16'h4000, 16'h3C00, 16'h4200, 16'h4000, 16'h4200, 16'h7E00,
                           16'h7C00, 16'h3C01, 16'h3C01, 16'h0001, 16'h0001, 16'h7BFF, 16'h3C00, 16'h3C00, 16'h3C00};
  logic [15:0] vy [NV] = '{16'h4000, 16'h7BFF, 16'h4000, 16'h3C00, 16'h4000, 16'h7BFF, 16'h4200, 16'h3C00,
                           16'h0000, 16'h3C01, 16'h3C01, 16'h0001, 16'h0001, 16'h7BFF, 16'h3C00, 16'h3C00, 16'h4000};
  logic [15:0] vz [NV] = '{16'h3C00, 16'h0000, 16'h0000, 16'hBC00, 16'h3C00, 16'h3C00, 16'h7C00, 16'h0000,
                           16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00};
  logic [7:0]  vc [NV] = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1E, 8'h14, 8'h18, 8'h1C,
                           8'h1C, 8'h1C, 8'h3C, 8'h1C, 8'h3C, 8'h0C, 8'h1D, 8'h2D, 8'hDC};
  logic [15:0] vr [NV] = '{16'h4200, 16'h7C00, 16'h4400, 16'h0000, 16'hC500, 16'h4200, 16'h4880, 16'h7E00,
                           16'h7E00, 16'h3C02, 16'h3C03, 16'h0000, 16'h0001, 16'h7BFF, 16'h0000, 16'h8000, 16'h4200};
  logic [3:0]  vf [NV] = '{4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                           4'h8, 4'h1, 4'h1, 4'h3, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0};

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_tag = '0;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v);
    req_valid = 1'b1;
    req_x     = vx[v];
    req_y     = vy[v];
    req_z     = vz[v];
    req_ctrl  = vc[v];
  endtask

  task automatic note_accept(input int v);
    exp_t e;
    e.res = vr[v];
    e.flg = vf[v];
    e.tag = exp_tag;
    exp_q.push_back(e);
    exp_tag = exp_tag + 4'd1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    reset     = 1'b0;
    step();
    step();
    reset = 1'b1;
    exp_q.delete();
    exp_tag = '0;
  endtask

  task automatic check_head(input string name);
    exp_t e;
    e = exp_q.pop_front();
    check({name, "_tag"},    32'(rsp_tag),    32'(e.tag));
    check({name, "_result"}, 32'(rsp_result), 32'(e.res));
    check({name, "_flags"},  32'(rsp_flags),  32'(e.flg));
  endtask

  // Sends n vectors starting at base and drains until every expected response is seen.
  task automatic stream(input string name, input int n, input int base, input bit rnd, output int cycles);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    while ((sent < n || exp_q.size() > 0) && cyc < 1000) begin
      if (sent < n) drive((base + sent) % NV);
      else req_valid = 1'b0;
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check({name, "_unexpected_rsp"}, 32'(rsp_valid), 32'd0);
        else check_head(name);
      end
      check({name, "_occ_bound"}, 32'(occupancy <= 3'(DEPTH)), 32'd1);
      acc = req_valid && req_ready;
      step();
      if (acc) begin
        note_accept((base + sent) % NV);
        sent++;
      end
      cyc++;
    end
    req_valid = 1'b0;
    check({name, "_done"}, 32'(sent == n && exp_q.size() == 0), 32'd1);
    cycles = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   k;
    bit   acc;
    exp_t e;

    do_reset();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);

    // Single op: accept, then response visible after the following edge.
    drive(0);
    check("single_req_ready", 32'(req_ready), 32'd1);
    step();
    note_accept(0);
    req_valid = 1'b0;
    check("single_lat1_valid", 32'(rsp_valid), 32'd0);
    check("single_lat1_busy",  32'(busy),      32'd1);
    step();
    check("single_lat2_valid", 32'(rsp_valid), 32'd1);
    check("single_occupancy",  32'(occupancy), 32'd1);
    check("single_result_lit", 32'(rsp_result), 32'h4200);
    check_head("single");
    rsp_ready = 1'b1;
    step();
    check("single_popped_valid", 32'(rsp_valid), 32'd0);
    check("single_popped_busy",  32'(busy),      32'd0);

    // Every directed vector back-to-back; idle start gives one response per cycle.
    stream("vec", NV, 0, 1'b0, cyc);
    check("vec_cycles", 32'(cyc), 32'(NV + 2));

    // Backpressure: 6 requests offered with the consumer stalled.
    do_reset();
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (k < 6) drive(k);
      else req_valid = 1'b0;
      acc = req_valid && req_ready;
      if (rsp_valid) check("bp_head_stable", 32'(rsp_result), 32'(vr[0]));
      step();
      if (acc) begin
        note_accept(k);
        k++;
      end
    end
    check("bp_accepted",  32'(k),         32'd4);
    check("bp_occupancy", 32'(occupancy), 32'd4);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_head_tag",  32'(rsp_tag),   32'd0);
    stream("bp_drain", 2, 4, 1'b0, cyc);

    // 32 back-to-back requests; tags wrap after 15.
    do_reset();
    stream("full_rate", 32, 0, 1'b0, cyc);
    check("full_rate_cycles", 32'(cyc), 32'd34);

    // Random consumer stalls exercise push and pop together near full.
    stream("random", 60, 3, 1'b1, cyc);
    check("random_end_occ",  32'(occupancy), 32'd0);
    check("random_end_busy", 32'(busy),      32'd0);

    // Reset with three responses queued and S1 holding a fourth packet.
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(7 + c);
      acc = req_ready;
      step();
      if (acc) note_accept(7 + c);
    end
    req_valid = 1'b0;
    check("mid_occupancy", 32'(occupancy), 32'd3);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete();
    exp_tag = '0;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_occupancy", 32'(occupancy), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    stream("post_rst", 1, 2, 1'b0, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
